id_stage_pipe: RTL and testbench

//   Next-generation RV32I decode stage. Decodes LUI/AUIPC/OP-IMM/OP, drives regfile reads,

---
 rtl/id_stage_pipe.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode stage (LUI/AUIPC/OP-IMM/OP) with regfile read
// control, prioritised operand forwarding, load-use interlock and an ID/EX
// pipeline register using valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_valid_i / if_ready_o  upstream handshake for pc_i / inst_i
//   flush_i                  drops ID/EX content and the incoming instruction
//   reg{1,2}_read_o/addr_o   combinational regfile read requests
//   reg{1,2}_data_i          regfile read data
//   fwd_*_i                  NFWD forwarding sources, index 0 has priority
//   ex_valid_o / ex_ready_i  downstream handshake for the ID/EX register
//   aluop_o .. wreg_o        registered ID/EX payload
//   stall_cnt_o              saturating count of load-use bubbles
//
// Optional feature: define ID_ILLEGAL_EXC_EN to add the registered illegal_o
// output and to treat funct7=0x20 on operations without an alternate form as
// illegal.

module id_stage_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NFWD  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          inst_i,
    input  logic                 flush_i,
    output logic                 reg1_read_o,
    output logic                 reg2_read_o,
    output logic [4:0]           reg1_addr_o,
    output logic [4:0]           reg2_addr_o,
    input  logic [XLEN-1:0]      reg1_data_i,
    input  logic [XLEN-1:0]      reg2_data_i,
    input  logic [NFWD-1:0]      fwd_wreg_i,
    input  logic [NFWD*5-1:0]    fwd_wd_i,
    input  logic [NFWD*XLEN-1:0] fwd_wdata_i,
    input  logic [NFWD-1:0]      fwd_load_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [7:0]           aluop_o,
    output logic [2:0]           alusel_o,
    output logic [XLEN-1:0]      reg1_o,
    output logic [XLEN-1:0]      reg2_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
`ifdef ID_ILLEGAL_EXC_EN
    output logic                 illegal_o,
`endif
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_STALL} state_t;

    state_t state;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    logic [7:0]      d_aluop;
    logic [2:0]      d_alusel;
    logic [XLEN-1:0] d_imm;
    logic            d_re1;
    logic            d_re2;
    logic            d_wreg;
    logic            d_rs1_pc;
    logic            d_illegal;

    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;
    logic            fwd1_load;
    logic            fwd2_load;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    logic adv;
    logic hazard;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign reg1_addr_o = inst_i[19:15];
    assign reg2_addr_o = inst_i[24:20];
    assign reg1_read_o = d_re1;
    assign reg2_read_o = d_re2;

    // Instruction decode; any unrecognised encoding collapses to a NOP.
    always_comb begin
        d_aluop   = EXE_NOP_OP;
        d_alusel  = EXE_RES_NOP;
        d_imm     = '0;
        d_re1     = 1'b0;
        d_re2     = 1'b0;
        d_wreg    = 1'b0;
        d_rs1_pc  = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_aluop  = EXE_OR_OP;
                d_alusel = EXE_RES_LOGIC;
                d_imm    = XLEN'($signed({inst_i[31:12], 12'h000}));
                d_wreg   = 1'b1;
            end
            OPC_AUIPC: begin
                d_aluop  = EXE_ADD_OP;
                d_alusel = EXE_RES_ARITH;
                d_imm    = XLEN'($signed({inst_i[31:12], 12'h000}));
                d_wreg   = 1'b1;
                d_rs1_pc = 1'b1;
            end
            OPC_OPIMM: begin
                d_re1  = 1'b1;
                d_wreg = 1'b1;
                d_imm  = XLEN'($signed(inst_i[31:20]));
                case (funct3)
                    3'b000: begin d_aluop = EXE_ADD_OP;  d_alusel = EXE_RES_ARITH; end
                    3'b010: begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITH; end
                    3'b011: begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITH; end
                    3'b100: begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; end
                    3'b110: begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; end
                    3'b111: begin d_aluop = EXE_AND_OP;  d_alusel = EXE_RES_LOGIC; end
                    3'b001: begin
                        d_aluop  = EXE_SLL_OP;
                        d_alusel = EXE_RES_SHIFT;
                        d_imm    = XLEN'(inst_i[24:20]);
                        d_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
`ifdef ID_ILLEGAL_EXC_EN
                        if (funct7 == F7_ALT) d_illegal = 1'b1;
`endif
                    end
                    default: begin
                        d_aluop  = (funct7 == F7_ALT) ? EXE_SRA_OP : EXE_SRL_OP;
                        d_alusel = EXE_RES_SHIFT;
                        d_imm    = XLEN'(inst_i[24:20]);
                        d_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                d_re1  = 1'b1;
                d_re2  = 1'b1;
                d_wreg = 1'b1;
                d_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
`ifdef ID_ILLEGAL_EXC_EN
                // Only ADD/SUB and SRL/SRA have a funct7=0x20 variant.
                if ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101))
                    d_illegal = 1'b1;
`endif
                case (funct3)
                    3'b000: begin
                        d_aluop  = (funct7 == F7_ALT) ? EXE_SUB_OP : EXE_ADD_OP;
                        d_alusel = EXE_RES_ARITH;
                    end
                    3'b001: begin d_aluop = EXE_SLL_OP;  d_alusel = EXE_RES_SHIFT; end
                    3'b010: begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITH; end
                    3'b011: begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITH; end
                    3'b100: begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; end
                    3'b101: begin
                        d_aluop  = (funct7 == F7_ALT) ? EXE_SRA_OP : EXE_SRL_OP;
                        d_alusel = EXE_RES_SHIFT;
                    end
                    3'b110: begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; end
                    default: begin d_aluop = EXE_AND_OP; d_alusel = EXE_RES_LOGIC; end
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
        // Illegal encodings read nothing so they can never raise an interlock.
        if (d_illegal) begin
            d_aluop  = EXE_NOP_OP;
            d_alusel = EXE_RES_NOP;
            d_imm    = '0;
            d_re1    = 1'b0;
            d_re2    = 1'b0;
            d_wreg   = 1'b0;
            d_rs1_pc = 1'b0;
        end
    end

    // Forwarding match; scanning from the oldest source down lets index 0 win.
    always_comb begin
        fwd1_data = reg1_data_i;
        fwd2_data = reg2_data_i;
        fwd1_load = 1'b0;
        fwd2_load = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == reg1_addr_o)) begin
                fwd1_data = fwd_wdata_i[XLEN*k +: XLEN];
                fwd1_load = fwd_load_i[k];
            end
            if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == reg2_addr_o)) begin
                fwd2_data = fwd_wdata_i[XLEN*k +: XLEN];
                fwd2_load = fwd_load_i[k];
            end
        end
    end

    // Operand select: x0 reads as zero, non-read ports take pc/zero or imm.
    always_comb begin
        if (!d_re1)                  op1 = d_rs1_pc ? pc_i : '0;
        else if (reg1_addr_o == '0)  op1 = '0;
        else                         op1 = fwd1_data;
        if (!d_re2)                  op2 = d_imm;
        else if (reg2_addr_o == '0)  op2 = '0;
        else                         op2 = fwd2_data;
    end

    assign hazard = if_valid_i &&
                    ((d_re1 && (reg1_addr_o != '0) && fwd1_load) ||
                     (d_re2 && (reg2_addr_o != '0) && fwd2_load));
    assign adv        = (state != ST_FULL) || ex_ready_i;
    assign if_ready_o = flush_i || (adv && !hazard);

    // ID/EX register and EMPTY/FULL/STALL sequencing; flush takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            ex_valid_o  <= 1'b0;
            aluop_o     <= EXE_NOP_OP;
            alusel_o    <= EXE_RES_NOP;
            reg1_o      <= '0;
            reg2_o      <= '0;
            imm_o       <= '0;
            pc_o        <= '0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
            illegal_o   <= 1'b0;
`endif
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            state      <= ST_EMPTY;
            ex_valid_o <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
            illegal_o  <= 1'b0;
`endif
        end else if (adv) begin
            if (hazard) begin
                state      <= ST_STALL;
                ex_valid_o <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
                illegal_o  <= 1'b0;
`endif
                if (stall_cnt_o != '1)
                    stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end else if (if_valid_i) begin
                state      <= ST_FULL;
                ex_valid_o <= 1'b1;
                aluop_o    <= d_aluop;
                alusel_o   <= d_alusel;
                reg1_o     <= op1;
                reg2_o     <= op2;
                imm_o      <= d_imm;
                pc_o       <= pc_i;
                wd_o       <= d_illegal ? 5'd0 : rd;
                wreg_o     <= d_wreg && (rd != 5'd0);
`ifdef ID_ILLEGAL_EXC_EN
                illegal_o  <= d_illegal;
`endif
            end else begin
                state      <= ST_EMPTY;
                ex_valid_o <= 1'b0;
`ifdef ID_ILLEGAL_EXC_EN
                illegal_o  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe.
// Uses a 3-bit stall counter so saturation is reachable in a few cycles.

module tb_id_stage_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NFWD  = 2;
    localparam int unsigned CNT_W = 3;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [2:0] RES_NOP   = 3'd0;
    localparam logic [2:0] RES_LOGIC = 3'd1;
    localparam logic [2:0] RES_SHIFT = 3'd2;
    localparam logic [2:0] RES_ARITH = 3'd4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_valid_i;
    logic                 if_ready_o;
    logic [XLEN-1:0]      pc_i;
    logic [31:0]          inst_i;
    logic                 flush_i;
    logic                 reg1_read_o, reg2_read_o;
    logic [4:0]           reg1_addr_o, reg2_addr_o;
    logic [XLEN-1:0]      reg1_data_i, reg2_data_i;
    logic [NFWD-1:0]      fwd_wreg_i;
    logic [NFWD*5-1:0]    fwd_wd_i;
    logic [NFWD*XLEN-1:0] fwd_wdata_i;
    logic [NFWD-1:0]      fwd_load_i;
    logic                 ex_valid_o;
    logic                 ex_ready_i;
    logic [7:0]           aluop_o;
    logic [2:0]           alusel_o;
    logic [XLEN-1:0]      reg1_o, reg2_o, imm_o, pc_o;
    logic [4:0]           wd_o;
    logic                 wreg_o;
`ifdef ID_ILLEGAL_EXC_EN
    logic                 illegal_o;
`endif
    logic [CNT_W-1:0]     stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
        .fwd_wdata_i(fwd_wdata_i), .fwd_load_i(fwd_load_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .imm_o(imm_o), .pc_o(pc_o),
        .wd_o(wd_o), .wreg_o(wreg_o),
`ifdef ID_ILLEGAL_EXC_EN
        .illegal_o(illegal_o),
`endif
        .stall_cnt_o(stall_cnt_o)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_wreg_i  = '0;
        fwd_wd_i    = '0;
        fwd_wdata_i = '0;
        fwd_load_i  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid_i = 1'b0; pc_i = '0; inst_i = '0; flush_i = 1'b0;
        reg1_data_i = '0; reg2_data_i = '0; ex_ready_i = 1'b1;
        clear_fwd();
        tick(); tick();
        checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid_o); end
        checks++; if (aluop_o !== OP_NOP) begin errors++; $display("FAIL reset_aluop got %h want %h", aluop_o, OP_NOP); end
        checks++; if (alusel_o !== RES_NOP) begin errors++; $display("FAIL reset_alusel got %h want 0", alusel_o); end
        checks++; if ({reg1_o, reg2_o, imm_o, pc_o, wd_o, wreg_o} !== '0) begin errors++; $display("FAIL reset_data got nonzero payload"); end
        checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt_o); end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        if_valid_i = 1'b1; inst_i = 32'h0050_0093; pc_i = 32'h10;
        #1;
        checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL addi_ready got %0b want 1", if_ready_o); end
        checks++; if (reg1_read_o !== 1'b1 || reg2_read_o !== 1'b0) begin errors++; $display("FAIL addi_re got %0b%0b want 10", reg1_read_o, reg2_read_o); end
        tick();
        if_valid_i = 1'b0;
        checks++; if (ex_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", ex_valid_o); end
        checks++; if (aluop_o !== OP_ADD || alusel_o !== RES_ARITH) begin errors++; $display("FAIL addi_op got %h/%h want %h/%h", aluop_o, alusel_o, OP_ADD, RES_ARITH); end
        checks++; if (reg1_o !== 32'h0 || reg2_o !== 32'h5 || imm_o !== 32'h5) begin errors++; $display("FAIL addi_ops got %h %h %h want 0 5 5", reg1_o, reg2_o, imm_o); end
        checks++; if (wd_o !== 5'd1 || wreg_o !== 1'b1 || pc_o !== 32'h10) begin errors++; $display("FAIL addi_wd got %0d %0b %h want 1 1 10", wd_o, wreg_o, pc_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b want 0", ex_valid_o); end
    endtask

    task automatic test_forward();
        if_valid_i = 1'b1; inst_i = 32'h0020_81B3; pc_i = 32'h20;
        reg1_data_i = 32'h99; reg2_data_i = 32'h33;
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h22, 32'h11};
        tick();
        checks++; if (reg1_o !== 32'h11 || reg2_o !== 32'h33) begin errors++; $display("FAIL fwd_prio got %h %h want 11 33", reg1_o, reg2_o); end
        checks++; if (wd_o !== 5'd3 || aluop_o !== OP_ADD) begin errors++; $display("FAIL fwd_dec got %0d %h want 3 %h", wd_o, aluop_o, OP_ADD); end
        fwd_wreg_i = 2'b10;
        tick();
        checks++; if (reg1_o !== 32'h22) begin errors++; $display("FAIL fwd_src1 got %h want 22", reg1_o); end
        fwd_wreg_i = 2'b00;
        tick();
        checks++; if (reg1_o !== 32'h99) begin errors++; $display("FAIL fwd_none got %h want 99", reg1_o); end
        // Both sources match x1 but only the older one is a load: no interlock.
        fwd_wreg_i = 2'b11; fwd_load_i = 2'b10;
        #1;
        checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL fwd_load_shadow got %0b want 1", if_ready_o); end
        tick();
        checks++; if (reg1_o !== 32'h11 || ex_valid_o !== 1'b1) begin errors++; $display("FAIL fwd_shadow_data got %h %0b want 11 1", reg1_o, ex_valid_o); end
        // Forward to x0 is ignored, including its load flag.
        inst_i = 32'h0020_01B3; fwd_wreg_i = 2'b01; fwd_wd_i = '0; fwd_wdata_i = {32'h0, 32'hDEAD}; fwd_load_i = 2'b01;
        #1;
        checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL x0_no_hazard got %0b want 1", if_ready_o); end
        tick();
        checks++; if (reg1_o !== 32'h0 || reg2_o !== 32'h33) begin errors++; $display("FAIL x0_zero got %h %h want 0 33", reg1_o, reg2_o); end
        if_valid_i = 1'b0; clear_fwd();
        tick();
    endtask

    task automatic test_load_use();
        if_valid_i = 1'b1; inst_i = 32'h0020_81B3;
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_wdata_i = {32'h0, 32'h44}; fwd_load_i = 2'b01;
        #1;
        checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL lu_ready got %0b want 0", if_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0 || stall_cnt_o !== 3'd1) begin errors++; $display("FAIL lu_bubble got %0b %0d want 0 1", ex_valid_o, stall_cnt_o); end
        fwd_load_i = 2'b00;
        #1;
        checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", if_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b1 || reg1_o !== 32'h44 || stall_cnt_o !== 3'd1) begin errors++; $display("FAIL lu_issue got %0b %h %0d want 1 44 1", ex_valid_o, reg1_o, stall_cnt_o); end
        if_valid_i = 1'b0; clear_fwd();
        tick();
    endtask

    task automatic test_backpressure();
        if_valid_i = 1'b1; inst_i = 32'h0050_0093; pc_i = 32'h30;
        tick();
        ex_ready_i = 1'b0; inst_i = 32'h1234_52B7; pc_i = 32'h34;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b want 0", i, if_ready_o); end
            tick();
            checks++; if (ex_valid_o !== 1'b1 || aluop_o !== OP_ADD || reg2_o !== 32'h5 || wd_o !== 5'd1 || pc_o !== 32'h30) begin
                errors++; $display("FAIL bp_hold[%0d] got %0b %h %h %0d %h", i, ex_valid_o, aluop_o, reg2_o, wd_o, pc_o);
            end
        end
        ex_ready_i = 1'b1;
        tick();
        if_valid_i = 1'b0;
        checks++; if (aluop_o !== OP_OR || alusel_o !== RES_LOGIC || reg1_o !== 32'h0 || reg2_o !== 32'h1234_5000 || wd_o !== 5'd5) begin
            errors++; $display("FAIL lui got %h %h %h %h %0d", aluop_o, alusel_o, reg1_o, reg2_o, wd_o);
        end
        tick();
    endtask

    task automatic test_decode();
        reg1_data_i = 32'd10; reg2_data_i = 32'd20; if_valid_i = 1'b1;
        inst_i = 32'h0000_1317; pc_i = 32'h100;
        tick();
        checks++; if (aluop_o !== OP_ADD || alusel_o !== RES_ARITH || reg1_o !== 32'h100 || reg2_o !== 32'h1000 || wd_o !== 5'd6) begin
            errors++; $display("FAIL auipc got %h %h %h %h %0d", aluop_o, alusel_o, reg1_o, reg2_o, wd_o);
        end
        inst_i = 32'h4020_83B3;
        tick();
        checks++; if (aluop_o !== OP_SUB || reg1_o !== 32'd10 || reg2_o !== 32'd20 || wd_o !== 5'd7) begin
            errors++; $display("FAIL sub got %h %h %h %0d", aluop_o, reg1_o, reg2_o, wd_o);
        end
        inst_i = 32'h4030_D413;
        tick();
        checks++; if (aluop_o !== OP_SRA || alusel_o !== RES_SHIFT || reg1_o !== 32'd10 || reg2_o !== 32'd3 || imm_o !== 32'd3) begin
            errors++; $display("FAIL srai got %h %h %h %h %h", aluop_o, alusel_o, reg1_o, reg2_o, imm_o);
        end
        inst_i = 32'h0010_0013;
        tick();
        checks++; if (wreg_o !== 1'b0 || wd_o !== 5'd0 || aluop_o !== OP_ADD) begin errors++; $display("FAIL addi_x0 got %0b %0d %h", wreg_o, wd_o, aluop_o); end
        inst_i = 32'h0231_00B3;
        tick();
        checks++; if (ex_valid_o !== 1'b1 || wreg_o !== 1'b0 || aluop_o !== OP_NOP || alusel_o !== RES_NOP) begin
            errors++; $display("FAIL bad_funct7 got %0b %0b %h %h", ex_valid_o, wreg_o, aluop_o, alusel_o);
        end
        inst_i = 32'hFFFF_FFFF;
        tick();
        checks++; if (ex_valid_o !== 1'b1 || wreg_o !== 1'b0 || aluop_o !== OP_NOP) begin
            errors++; $display("FAIL illegal got %0b %0b %h want 1 0 00", ex_valid_o, wreg_o, aluop_o);
        end
`ifdef ID_ILLEGAL_EXC_EN
        checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag got %0b want 1", illegal_o); end
`endif
        // Flush beats backpressure and drops the incoming instruction.
        ex_ready_i = 1'b0; flush_i = 1'b1;
        #1;
        checks++; if (if_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", if_ready_o); end
        tick();
        checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid_o); end
        flush_i = 1'b0; ex_ready_i = 1'b1; if_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        if_valid_i = 1'b1; inst_i = 32'h0020_81B3;
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_load_i = 2'b01;
        tick(); tick();
        checks++; if (stall_cnt_o !== 3'd3) begin errors++; $display("FAIL stall3 got %0d want 3", stall_cnt_o); end
        // Hazard together with flush: flush wins, counter unchanged.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (stall_cnt_o !== 3'd3) begin errors++; $display("FAIL flush_stall got %0d want 3", stall_cnt_o); end
        fwd_load_i = 2'b00;
        tick();
        checks++; if (ex_valid_o !== 1'b1 || stall_cnt_o !== 3'd3) begin errors++; $display("FAIL pre_rst got %0b %0d want 1 3", ex_valid_o, stall_cnt_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ex_valid_o !== 1'b0 || stall_cnt_o !== '0 || aluop_o !== OP_NOP || alusel_o !== RES_NOP ||
                      {reg1_o, reg2_o, imm_o, pc_o, wd_o, wreg_o} !== '0) begin
            errors++; $display("FAIL async_rst got %0b %0d %h %h", ex_valid_o, stall_cnt_o, aluop_o, reg1_o);
        end
        if_valid_i = 1'b0; clear_fwd();
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_stall_saturate();
        if_valid_i = 1'b1; inst_i = 32'h0020_81B3;
        fwd_wreg_i = 2'b10; fwd_wd_i = {5'd2, 5'd0}; fwd_load_i = 2'b10;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (stall_cnt_o !== 3'd7) begin errors++; $display("FAIL stall7 got %0d want 7", stall_cnt_o); end
        tick(); tick();
        checks++; if (stall_cnt_o !== 3'd7 || ex_valid_o !== 1'b0) begin errors++; $display("FAIL stall_sat got %0d %0b want 7 0", stall_cnt_o, ex_valid_o); end
        if_valid_i = 1'b0; clear_fwd();
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_backpressure();
        test_decode();
        test_async_reset();
        test_stall_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
